// File: rtl/dct_quant_rle.sv
// dct_quant_rle: quantizes (dct1, dct2) coefficient pairs by an arithmetic right shift
// (rounding toward zero) and run-length encodes the result into (run, level) tokens,
// with zero-run-length (ZRL) and end-of-block (EOB) markers.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   in_valid/ready   input pair handshake; ready only while idle
//   dct1, dct2       signed coefficients, processed in that order
//   qshift           quantizer shift, captured with the pair
//   block_last       pair closes the current block (an EOB token follows)
//   out_valid/ready  registered token handshake
//   out_run          zeros preceding this level (MAX_RUN for ZRL)
//   out_level        signed quantized level (0 for ZRL/EOB)
//   out_eob          token is end-of-block
module dct_quant_rle #(
  parameter int DATA_W = 8,
  parameter int RUN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] dct1,
  input  logic [DATA_W-1:0] dct2,
  input  logic [2:0]        qshift,
  input  logic              block_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RUN_W-1:0]  out_run,
  output logic [DATA_W-1:0] out_level,
  output logic              out_eob
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] C1   = 2'd1;
  localparam logic [1:0] C2   = 2'd2;
  localparam logic [1:0] EOB  = 2'd3;

  localparam logic [RUN_W-1:0] MAX_RUN = '1;

  logic [1:0]        state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [DATA_W-1:0] c1_q, c2_q;
  logic [2:0]        qs_q;
  logic              last_q;

  logic              valid_d, eob_d;
  logic [RUN_W-1:0]  orun_d;
  logic [DATA_W-1:0] olevel_d;

  logic [DATA_W-1:0] cur, q;
  logic              free, done;

  // Magnitude is taken one bit wider so the most negative input quantizes correctly.
  function automatic logic [DATA_W-1:0] quant(input logic [DATA_W-1:0] c,
                                              input logic [2:0] sh);
    logic [DATA_W:0] ext, mag, m;
    ext = {c[DATA_W-1], c};
    mag = c[DATA_W-1] ? (~ext + 1'b1) : ext;
    m   = mag >> sh;
    return c[DATA_W-1] ? DATA_W'(~m + 1'b1) : DATA_W'(m);
  endfunction

  assign in_ready = (state_q == IDLE);
  assign cur      = (state_q == C1) ? c1_q : c2_q;
  assign q        = quant(cur, qs_q);
  assign free     = !out_valid || out_ready;

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    valid_d  = out_valid && !out_ready;
    orun_d   = out_run;
    olevel_d = out_level;
    eob_d    = out_eob;
    done     = 1'b0;
    case (state_q)
      IDLE: if (in_valid) state_d = C1;
      C1, C2: begin
        if (q != '0) begin
          if (free) begin
            valid_d  = 1'b1;
            orun_d   = run_q;
            olevel_d = q;
            eob_d    = 1'b0;
            run_d    = '0;
            done     = 1'b1;
          end
        end else if (run_q != MAX_RUN) begin
          // Zeros are absorbed into the run without touching the output.
          run_d = run_q + 1'b1;
          done  = 1'b1;
        end else if (free) begin
          valid_d  = 1'b1;
          orun_d   = MAX_RUN;
          olevel_d = '0;
          eob_d    = 1'b0;
          run_d    = '0;
          done     = 1'b1;
        end
        if (done) begin
          if (state_q == C1) state_d = C2;
          else               state_d = last_q ? EOB : IDLE;
        end
      end
      EOB: begin
        if (free) begin
          // Trailing zeros still in the run are discarded here.
          valid_d  = 1'b1;
          orun_d   = '0;
          olevel_d = '0;
          eob_d    = 1'b1;
          run_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      run_q     <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      qs_q      <= '0;
      last_q    <= 1'b0;
      out_valid <= 1'b0;
      out_run   <= '0;
      out_level <= '0;
      out_eob   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      out_valid <= valid_d;
      out_run   <= orun_d;
      out_level <= olevel_d;
      out_eob   <= eob_d;
      if (in_valid && in_ready) begin
        c1_q   <= dct1;
        c2_q   <= dct2;
        qs_q   <= qshift;
        last_q <= block_last;
      end
    end
  end

endmodule

// File: tb/tb_dct_quant_rle.sv
// tb_dct_quant_rle: self-checking bench for dct_quant_rle. A token-level model predicts
// the token stream from each accepted pair; a negedge monitor compares every transferred
// token against it and checks that stalled outputs hold. Directed scenarios pin the
// model with literal token lists; a randomized phase exercises backpressure.
module tb_dct_quant_rle;

  localparam int DATA_W  = 8;
  localparam int RUN_W   = 4;
  localparam int MAX_RUN = (1 << RUN_W) - 1;

  logic              clk, rst;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] dct1, dct2;
  logic [2:0]        qshift;
  logic              block_last;
  logic              out_valid, out_ready;
  logic [RUN_W-1:0]  out_run;
  logic [DATA_W-1:0] out_level;
  logic              out_eob;

  dct_quant_rle #(.DATA_W(DATA_W), .RUN_W(RUN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dct1       (dct1),
    .dct2       (dct2),
    .qshift     (qshift),
    .block_last (block_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_run    (out_run),
    .out_level  (out_level),
    .out_eob    (out_eob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int run; int lvl; int eob;} tok_t;

  int   checks = 0;
  int   failures = 0;
  tok_t exp_q[$];
  int   mrun = 0;
  int   lg_run[$], lg_lvl[$], lg_eob[$], lg_cyc[$];
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   prev_stall = 0;
  int   p_run, p_lvl, p_eob;
  bit   rand_mode = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Quantizer from its definition: shift the magnitude, reapply the sign.
  function automatic int mquant(input int c, input int sh);
    int m;
    m = (c < 0 ? -c : c) >> sh;
    return (c < 0) ? -m : m;
  endfunction

  task automatic model_coef(input int qv);
    tok_t t;
    if (qv != 0) begin
      t = '{mrun, qv, 0}; exp_q.push_back(t); mrun = 0;
    end else if (mrun == MAX_RUN) begin
      t = '{MAX_RUN, 0, 0}; exp_q.push_back(t); mrun = 0;
    end else begin
      mrun++;
    end
  endtask

  // Monitor: away from the active edge; handshakes seen here complete at the next posedge.
  always @(negedge clk) begin
    tok_t e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      mrun = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_run", int'(out_run), p_run);
        chk("hold_level", int'($signed(out_level)), p_lvl);
        chk("hold_eob", int'(out_eob), p_eob);
      end
      if (out_valid && out_ready) begin
        lg_run.push_back(int'(out_run));
        lg_lvl.push_back(int'($signed(out_level)));
        lg_eob.push_back(int'(out_eob));
        lg_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_token: got (%0d,%0d,%0d), required none", out_run,
                   $signed(out_level), out_eob);
        end else begin
          e = exp_q.pop_front();
          chk("tok_run", int'(out_run), e.run);
          chk("tok_level", int'($signed(out_level)), e.lvl);
          chk("tok_eob", int'(out_eob), e.eob);
        end
      end
      prev_stall = out_valid && !out_ready;
      p_run = int'(out_run);
      p_lvl = int'($signed(out_level));
      p_eob = int'(out_eob);
      if (in_valid && in_ready) begin
        acc_cyc = cyc;
        model_coef(mquant(int'($signed(dct1)), int'(qshift)));
        model_coef(mquant(int'($signed(dct2)), int'(qshift)));
        if (block_last) begin
          e = '{0, 0, 1}; exp_q.push_back(e); mrun = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1 out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  task automatic clear_log();
    lg_run.delete(); lg_lvl.delete(); lg_eob.delete(); lg_cyc.delete();
  endtask

  task automatic expect_tok(input int idx, input int r, input int l, input int e);
    chk("log_len", int'(lg_run.size() > idx), 1);
    if (lg_run.size() > idx) begin
      chk("lit_run", lg_run[idx], r);
      chk("lit_level", lg_lvl[idx], l);
      chk("lit_eob", lg_eob[idx], e);
    end
  endtask

  task automatic send(input int a, input int b, input int sh, input bit last);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    dct1 = DATA_W'(a);
    dct2 = DATA_W'(b);
    qshift = 3'(sh);
    block_last = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk("accept_timeout", int'(ok), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    chk("out_valid_timeout", int'(ok), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst_checked();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_run", int'(out_run), 0);
    chk("rst_out_level", int'(out_level), 0);
    chk("rst_out_eob", int'(out_eob), 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 0; dct1 = 0; dct2 = 0; qshift = 0; block_last = 0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_out_eob", int'(out_eob), 0);
    chk("init_in_ready", int'(in_ready), 1);

    // 1: asynchronous reset mid-cycle with a token held
    out_ready = 1'b0;
    send(20, 0, 0, 1'b1);
    wait_out_valid();
    pulse_rst_checked();

    // 2: basic pair with EOB, timing on consecutive cycles
    out_ready = 1'b1;
    clear_log();
    send(50, 30, 0, 1'b1);
    idle(8);
    expect_tok(0, 0, 50, 0);
    expect_tok(1, 0, 30, 0);
    expect_tok(2, 0, 0, 1);
    chk("lat_dct1", lg_cyc.size() > 0 ? lg_cyc[0] - acc_cyc : -1, 2);
    chk("consec_12", lg_cyc.size() > 2 ? lg_cyc[1] + 1 - lg_cyc[2] + lg_cyc[1] - lg_cyc[0] : -1,
        1);
    chk("post_eob_ready", int'(in_ready), 1);

    // 3: zeros carried across pairs, trailing zero discarded, -128 quantized
    clear_log();
    send(3, -3, 2, 1'b0);
    send(-128, 0, 2, 1'b1);
    idle(8);
    chk("s3_count", lg_run.size(), 2);
    expect_tok(0, 2, -32, 0);
    expect_tok(1, 0, 0, 1);

    // 4: eighteen zeros produce one ZRL plus a run of 2
    clear_log();
    for (int i = 0; i < 9; i++) send(0, 0, 0, 1'b0);
    send(5, 0, 0, 1'b1);
    idle(8);
    chk("s4_count", lg_run.size(), 3);
    expect_tok(0, MAX_RUN, 0, 0);
    expect_tok(1, 2, 5, 0);
    expect_tok(2, 0, 0, 1);

    // 5: backpressure for 5 cycles after the first token appears
    clear_log();
    out_ready = 1'b0;
    send(50, 30, 0, 1'b1);
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    idle(8);
    chk("s5_count", lg_run.size(), 3);
    expect_tok(0, 0, 50, 0);
    expect_tok(1, 0, 30, 0);
    expect_tok(2, 0, 0, 1);

    // 6: reset while C2 is stalled behind a pending token
    out_ready = 1'b0;
    send(9, 4, 0, 1'b1);
    wait_out_valid();
    idle(2);
    pulse_rst_checked();
    out_ready = 1'b1;
    clear_log();
    send(7, 0, 0, 1'b1);
    idle(8);
    chk("s6_count", lg_run.size(), 2);
    expect_tok(0, 0, 7, 0);
    expect_tok(1, 0, 0, 1);

    // Randomized: sparse coefficients, random shift/last, random backpressure
    rand_mode = 1;
    for (int i = 0; i < 300; i++) begin
      int a, b;
      a = ($urandom_range(0, 1) == 0) ? 0 : int'($signed(8'($urandom)));
      b = ($urandom_range(0, 2) != 0) ? 0 : int'($signed(8'($urandom)));
      send(a, b, $urandom_range(0, 7), ($urandom_range(0, 3) == 0));
    end
    send(1, 0, 0, 1'b1);
    rand_mode = 0;
    @(posedge clk); #1 out_ready = 1'b1;
    idle(20);
    chk("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
